// File: rtl/stage_f.sv
// Fetch stage for a dual-ISA (ARM / RISC-V) pipeline with a request/acknowledge
// instruction-memory port. At most one request is outstanding; redirects win over stalls.
module stage_f (
    input  logic        clk,
    input  logic        rst,
    input  logic        arm,
    input  logic        stallF,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        IReqF,
    output logic [31:0] IAddrF,
    input  logic        IAckF,
    input  logic [31:0] IRdataF,
    output logic [31:0] PCF,
    output logic [31:0] PCPlus4F,
    output logic [31:0] RDD
);

    typedef enum logic [1:0] {
        S_REQ,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] rdd_q, rdd_d;
    logic [31:0] buf_q, buf_d;
    logic [31:0] old_pc_q, old_pc_d;

    logic        redirect;
    logic [31:0] target;
    logic        ack;

    always_comb begin
        redirect = arm ? PCSrcW : PCSrcE;
        target   = arm ? ResultW : PCTargetE;
        IReqF    = !rst && (state_q != S_HOLD);
        // In DRAIN the memory is still servicing the pre-redirect address.
        IAddrF   = (state_q == S_DRAIN) ? old_pc_q : pc_q;
        ack      = IAckF && IReqF;
        PCF      = pc_q;
        PCPlus4F = pc_q + 32'd4;
        RDD      = rdd_q;
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        rdd_d    = rdd_q;
        buf_d    = buf_q;
        old_pc_d = old_pc_q;

        case (state_q)
            S_REQ: begin
                if (ack) begin
                    if (redirect) begin
                        pc_d  = target;
                        rdd_d = 32'b0;
                    end else if (!stallF) begin
                        rdd_d = IRdataF;
                        pc_d  = pc_q + 32'd4;
                    end else begin
                        buf_d   = IRdataF;
                        state_d = S_HOLD;
                    end
                end else if (redirect) begin
                    old_pc_d = pc_q;
                    pc_d     = target;
                    if (!stallF) begin
                        rdd_d = 32'b0;
                    end
                    state_d  = S_DRAIN;
                end else if (!stallF) begin
                    rdd_d = 32'b0;
                end
            end

            S_HOLD: begin
                if (redirect) begin
                    buf_d   = 32'b0;
                    pc_d    = target;
                    if (!stallF) begin
                        rdd_d = 32'b0;
                    end
                    state_d = S_REQ;
                end else if (!stallF) begin
                    rdd_d   = buf_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_REQ;
                end
            end

            S_DRAIN: begin
                // The youngest redirect wins; the draining word is always thrown away.
                if (redirect) begin
                    pc_d = target;
                end
                if (ack) begin
                    state_d = S_REQ;
                end
                if (!stallF) begin
                    rdd_d = 32'b0;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_REQ;
            pc_q     <= 32'b0;
            rdd_q    <= 32'b0;
            buf_q    <= 32'b0;
            old_pc_q <= 32'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            rdd_q    <= rdd_d;
            buf_q    <= buf_d;
            old_pc_q <= old_pc_d;
        end
    end

endmodule

// File: doc/stage_f.md
STAGE_F -- requirements
Module: stage_f

Interface
REQ-001 clk  input  1  single clock; all state updates on posedge clk.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 arm  input  1  ISA select: 1 = ARM, 0 = RISC-V; static after reset.
REQ-004 stallF  input  1  hazard-unit stall of the fetch stage.
REQ-005 PCSrcE  input  1  RISC-V taken branch or jump redirect; used only when arm=0.
REQ-006 PCTargetE  input  32  RISC-V redirect target.
REQ-007 PCSrcW  input  1  ARM write-to-PC redirect; used only when arm=1.
REQ-008 ResultW  input  32  ARM redirect target.
REQ-009 IReqF  output  1  instruction-memory request; held high until acknowledged.
REQ-010 IAddrF  output  32  request address; stable while IReqF=1 and no IAckF.
REQ-011 IAckF  input  1  one-cycle response strobe; valid only while IReqF=1.
REQ-012 IRdataF  input  32  instruction word; valid with IAckF.
REQ-013 PCF  output  32  current fetch PC; registered.
REQ-014 PCPlus4F  output  32  PCF+4, combinational; ARM decode uses it as r15 (PC+8).
REQ-015 RDD  output  32  registered instruction word for decode; 32'b0 denotes a bubble.

Function
REQ-016 State machine SHALL have three states: REQ, HOLD, DRAIN; encoding is free.
REQ-017 redirect SHALL be (arm ? PCSrcW : PCSrcE); target SHALL be (arm ? ResultW : PCTargetE).
REQ-018 PCPlus4F and all PC arithmetic SHALL be 32-bit modulo 2^32; 0xFFFFFFFC+4 = 0x00000000.
REQ-019 IReqF SHALL be 1 in REQ and DRAIN and 0 in HOLD; IAddrF SHALL equal PCF in REQ and the latched old PC in DRAIN.
REQ-020 IAckF SHALL be ignored whenever IReqF=0.
REQ-021 REQ with IAckF and redirect: discard IRdataF; PCF <= target; RDD <= 0; stay in REQ.
REQ-022 REQ with IAckF, no redirect, stallF=0: RDD <= IRdataF; PCF <= PCF+4; stay in REQ.
REQ-023 REQ with IAckF, no redirect, stallF=1: latch IRdataF into a buffer; PCF and RDD unchanged; go to HOLD.
REQ-024 REQ without IAckF, with redirect: latch target as the pending PC; PCF <= target; go to DRAIN, keeping the old address on IAddrF.
REQ-025 REQ without IAckF, no redirect: if stallF=0, RDD <= 0 (bubble); otherwise RDD is held; PCF is unchanged.
REQ-026 HOLD with redirect: drop the buffer; PCF <= target; RDD <= 0 if stallF=0, else held; go to REQ.
REQ-027 HOLD, no redirect, stallF=0: RDD <= buffer; PCF <= PCF+4; go to REQ.
REQ-028 HOLD, no redirect, stallF=1: no state change.
REQ-029 DRAIN with IAckF: discard the data; go to REQ; PCF already holds the target.
REQ-030 DRAIN with a further redirect: overwrite PCF with the newest target; the youngest redirect wins.
REQ-031 In DRAIN, RDD <= 0 when stallF=0.
REQ-032 Redirect SHALL take priority over stallF in every state.
REQ-033 At most one request SHALL be outstanding at any time.
REQ-034 With zero-wait memory (IAckF in the same cycle as IReqF) and no stalls, throughput SHALL be one instruction per cycle.
REQ-035 RDD SHALL reach decode one cycle after IAckF, aligned with decode's capture of PCF.

Reset
REQ-036 When rst=1 at posedge, stage_f SHALL set: state = REQ, PCF = 0x00000000, RDD = 0x00000000, buffer = 0.
REQ-037 A reset during DRAIN or HOLD SHALL abandon the outstanding request and the buffer.
REQ-038 The memory SHALL drop any request whose IReqF is deasserted; stage_f ignores late acknowledges (REQ-020).
REQ-039 While rst=1, IReqF SHALL be 0.

Verification
REQ-040 Reset, zero-wait memory returning 0xA0000000+addr, no stalls -> PCF = 0, 4, 8; RDD = 0xA0000000, 0xA0000004, one per cycle after the first.
REQ-041 IAckF delayed 2 cycles at PC 0x10 -> two RDD=0 bubbles, PCF held at 0x10, then RDD = word and PCF = 0x14.
REQ-042 arm=0, PCSrcE=1, PCTargetE=0x200 while a request to 0x40 is pending -> state DRAIN, IAddrF stays 0x40, its data is discarded; next request goes to 0x200; RDD bubbles only in between.
REQ-043 IAckF with stallF=1 for 3 cycles -> HOLD, IReqF=0, RDD held; on release RDD = buffered word and PCF += 4.
REQ-044 arm=1, PCSrcW=1, ResultW=0x8, arriving together with IAckF and stallF=1 -> word discarded, PCF = 0x8, state REQ.
REQ-045 rst asserted in DRAIN, stale IAckF in the next cycle -> ignored; PCF = 0, RDD = 0, first request goes to 0x0.
